gshare_predictor: RTL and testbench

- Parametrised direction predictor for the pipelined RV32 core, one level up from a single 2-bit saturating counter.
- Holds a pattern history table (PHT) of 2^IDX_W saturating counters of CNT_W bits each, indexed gshare-style by PC XOR global history register (GHR).
- IF stage issues a combinational lookup. EX stage returns resolved outcomes to train the table and repair the speculative history after a mispredict.

---
 rtl/branch_pred_pkg.sv | 28 ++
 rtl/gshare_predictor_if.sv | 31 +++
 rtl/sat_counter_n.sv | 43 ++++
 rtl/gshare_predictor.sv | 78 +++++++
 tb/tb_gshare_predictor.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/branch_pred_pkg.sv
// Shared widths, counter limits and the pipeline tag type for the
// gshare direction predictor.
package branch_pred_pkg;

  localparam int PC_W_DEF  = 32'sd32;
  localparam int IDX_W_DEF = 32'sd5;
  localparam int GHR_W_DEF = 32'sd5;
  localparam int CNT_W_DEF = 32'sd2;

  function automatic int cnt_max(input int cnt_w);
    return (32'sd1 <<< cnt_w) - 32'sd1;
  endfunction

  // Weakly not-taken: one below the taken threshold.
  function automatic int cnt_init(input int cnt_w);
    return (32'sd1 <<< (cnt_w - 32'sd1)) - 32'sd1;
  endfunction

  localparam int CNT_MAX    = cnt_max(CNT_W_DEF);
  localparam int INIT_DEF   = cnt_init(CNT_W_DEF);
  localparam int GHR_PW_DEF = (GHR_W_DEF > 32'sd0) ? GHR_W_DEF : 32'sd1;

  typedef struct packed {
    logic [IDX_W_DEF-1:0]  idx;
    logic [GHR_PW_DEF-1:0] ghr;
  } bp_tag_t;

endpackage

// File: rtl/gshare_predictor_if.sv
// Lookup (IF) and training/repair (EX) signals of the gshare predictor.
interface gshare_predictor_if import branch_pred_pkg::*; #(
  parameter int PC_W  = PC_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int GHR_W = GHR_W_DEF
);

  localparam int GHR_PW = (GHR_W > 32'sd0) ? GHR_W : 32'sd1;

  logic              pred_valid;
  logic [PC_W-1:0]   pred_pc;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic [GHR_PW-1:0] pred_ghr;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic [GHR_PW-1:0] upd_ghr;
  logic              upd_taken;
  logic              upd_mispredict;

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_idx, upd_ghr, upd_taken, upd_mispredict,
    input  pred_taken, pred_idx, pred_ghr
  );

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_idx, upd_ghr, upd_taken, upd_mispredict,
    output pred_taken, pred_idx, pred_ghr
  );

endinterface

// File: rtl/sat_counter_n.sv
// One CNT_W-bit saturating direction counter; its MSB is the prediction.
module sat_counter_n import branch_pred_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int INIT  = cnt_init(CNT_W)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic taken,
  output logic pred
);

  localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_BOT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(INIT);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Saturating step toward the resolved direction.
  always_comb begin
    cnt_next_s = cnt_r;
    if (!en) begin
      cnt_next_s = cnt_r;
    end else if (taken) begin
      if (cnt_r == CNT_TOP) cnt_next_s = cnt_r;
      else                  cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      if (cnt_r == CNT_BOT) cnt_next_s = cnt_r;
      else                  cnt_next_s = cnt_r - CNT_ONE;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_r <= CNT_RST;
    else        cnt_r <= cnt_next_s;
  end

  assign pred = cnt_r[CNT_W-1];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PHT of saturating counters indexed by
// PC XOR global history, with speculative GHR shift and mispredict repair.
module gshare_predictor import branch_pred_pkg::*; #(
  parameter int PC_W  = PC_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int GHR_W = GHR_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int INIT  = cnt_init(CNT_W)
) (
  input  logic               clk,
  input  logic               reset,
  gshare_predictor_if.slave  bus
);

  localparam int N_ENT  = 32'sd1 <<< IDX_W;
  localparam int GHR_PW = (GHR_W > 32'sd0) ? GHR_W : 32'sd1;

  logic [IDX_W-1:0]  pc_idx_s;
  logic [IDX_W-1:0]  ghr_ext_s;
  logic [IDX_W-1:0]  idx_s;
  logic [GHR_PW-1:0] ghr_s;
  logic [N_ENT-1:0]  en_s;
  logic [N_ENT-1:0]  msb_s;
  logic              taken_s;

  assign pc_idx_s = bus.pred_pc[IDX_W+1:2];
  assign idx_s    = pc_idx_s ^ ghr_ext_s;
  assign taken_s  = msb_s[idx_s];

  assign bus.pred_idx   = idx_s;
  assign bus.pred_taken = taken_s;
  assign bus.pred_ghr   = ghr_s;

  if (GHR_W > 0) begin : g_ghr
    logic [GHR_W-1:0] ghr_r;
    logic [GHR_W-1:0] ghr_next_s;

    // Repair from the resolved branch outranks the wrong-path speculative shift.
    always_comb begin
      ghr_next_s = ghr_r;
      if (bus.upd_valid && bus.upd_mispredict) begin
        ghr_next_s = GHR_W'({bus.upd_ghr, bus.upd_taken});
      end else if (bus.pred_valid) begin
        ghr_next_s = GHR_W'({ghr_r, taken_s});
      end else begin
        ghr_next_s = ghr_r;
      end
    end

    // Global history register.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) ghr_r <= {GHR_W{1'b0}};
      else        ghr_r <= ghr_next_s;
    end

    assign ghr_s     = ghr_r;
    assign ghr_ext_s = IDX_W'(ghr_r);
  end else begin : g_no_ghr
    assign ghr_s     = 1'b0;
    assign ghr_ext_s = {IDX_W{1'b0}};
  end

  for (genvar i = 0; i < N_ENT; i++) begin : g_pht
    assign en_s[i] = bus.upd_valid && (bus.upd_idx == IDX_W'(i));

    sat_counter_n #(
      .CNT_W (CNT_W),
      .INIT  (INIT)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (en_s[i]),
      .taken (bus.upd_taken),
      .pred  (msb_s[i])
    );
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: directed scenarios plus random
// traffic, checked against an array/integer model of the predictor rules.
module tb_gshare_predictor;
  import branch_pred_pkg::*;

  localparam int PC_W   = 32;
  localparam int IDX_W  = 5;
  localparam int GHR_W  = 5;
  localparam int CNT_W  = 2;
  localparam int N_ENT  = 32;
  localparam int C_TOP  = 3;
  localparam int C_INIT = 1;
  localparam int THRESH = 2;

  typedef struct {
    int idx;
    int taken;
    int ghr;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gshare_predictor_if #(.PC_W(PC_W), .IDX_W(IDX_W), .GHR_W(GHR_W)) bus ();

  gshare_predictor #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W),
    .GHR_W (GHR_W),
    .CNT_W (CNT_W),
    .INIT  (C_INIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t exp_q[$];
  exp_t m_e;
  int   pht[N_ENT];
  int   ghr;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void model_reset();
    for (int i = 0; i < N_ENT; i++) pht[i] = C_INIT;
    ghr = 0;
  endfunction

  // One clock of stimulus: drive, record the expected lookup, then advance the model past the edge.
  task automatic cycle(input bit pv, input logic [31:0] pc, input bit uv, input int uidx,
                       input int ughr, input bit ut, input bit um);
    exp_t e;
    int   idx;
    @(negedge clk);
    bus.pred_valid     = pv;
    bus.pred_pc        = pc;
    bus.upd_valid      = uv;
    bus.upd_idx        = uidx[4:0];
    bus.upd_ghr        = ughr[4:0];
    bus.upd_taken      = ut;
    bus.upd_mispredict = um;
    idx     = int'((pc >> 2) % 32'd32) ^ ghr;
    e.idx   = idx;
    e.taken = (pht[idx] >= THRESH) ? 1 : 0;
    e.ghr   = ghr;
    exp_q.push_back(e);
    if (uv) begin
      if (ut) pht[uidx] = (pht[uidx] < C_TOP) ? pht[uidx] + 1 : C_TOP;
      else    pht[uidx] = (pht[uidx] > 0) ? pht[uidx] - 1 : 0;
    end
    if (uv && um)  ghr = (ughr * 2 + int'(ut)) % 32;
    else if (pv)   ghr = (ghr * 2 + e.taken) % 32;
  endtask

  // Short reset pulse strictly between a rising and the following falling edge.
  task automatic reset_pulse();
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        m_e = exp_q.pop_front();
        n_vec++;
        if (bus.pred_idx !== m_e.idx[4:0] || bus.pred_taken !== m_e.taken[0] ||
            bus.pred_ghr !== m_e.ghr[4:0]) begin
          n_err++;
          $display("FAIL lookup #%0d: got idx=%h taken=%b ghr=%b, want idx=%h taken=%b ghr=%b",
                   n_vec, bus.pred_idx, bus.pred_taken, bus.pred_ghr,
                   m_e.idx[4:0], m_e.taken[0], m_e.ghr[4:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pred_valid     = 1'b0;
    bus.pred_pc        = 32'h0;
    bus.upd_valid      = 1'b0;
    bus.upd_idx        = 5'd0;
    bus.upd_ghr        = 5'd0;
    bus.upd_taken      = 1'b0;
    bus.upd_mispredict = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;

    cycle(1'b1, 32'h40, 1'b0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0C, 1'b1, 3, 0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 32'h0C, 1'b1, 3, 0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0C, 1'b0, 0, 0, 1'b0, 1'b0);

    // Saturate entry 0x10, then steer three taken lookups onto it.
    cycle(1'b0, 32'h40, 1'b1, 16, 0, 1'b1, 1'b0);
    cycle(1'b0, 32'h40, 1'b1, 16, 0, 1'b1, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 0, 0, 1'b0, 1'b0);
    cycle(1'b1, 32'h44, 1'b0, 0, 0, 1'b0, 1'b0);
    cycle(1'b1, 32'h4C, 1'b0, 0, 0, 1'b0, 1'b0);
    cycle(1'b0, 32'h40, 1'b0, 0, 0, 1'b0, 1'b0);
    cycle(1'b1, 32'h5C, 1'b1, 9, 20, 1'b0, 1'b1);
    cycle(1'b0, 32'h40, 1'b0, 0, 0, 1'b0, 1'b0);

    reset_pulse();
    cycle(1'b0, 32'h40, 1'b0, 0, 0, 1'b0, 1'b0);
    cycle(1'b1, 32'h14, 1'b1, 5, 0, 1'b1, 1'b0);
    cycle(1'b0, 32'h14, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      int  uidx;
      bit  um;
      uidx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, N_ENT - 1);
      um   = ($urandom_range(0, 3) == 0);
      cycle(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)), uidx,
            $urandom_range(0, 31), 1'($urandom_range(0, 1)), um);
      if ($urandom_range(0, 99) == 0) reset_pulse();
    end

    cycle(1'b0, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked lookups, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
